risc16_imem_loader: RTL and testbench
=====================================

Name: risc16_imem_loader

Overview:
- Writer side of the RiSC-16 instruction memory; the fetch path and opcode decoder are the reader side.
- Accepts a byte stream of program words over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes each word to consecutive instruction-memory addresses and keeps a running checksum.
- Holds the CPU via cpu_hold until a complete load finishes.

Parameters:
- ADDR_W, 16, width of instruction-memory address, base address and word-count fields

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load request, sampled in IDLE or DONE
- abort  input  1  cancels a load in progress
- base_addr  input  ADDR_W  first imem address, latched on accepted start
- length  input  ADDR_W  number of 16-bit words to load, latched on accepted start
- s_valid  input  1  stream byte valid
- s_data  input  8  stream byte
- s_ready  output  1  loader can accept a byte
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  16  write data
- imem_we  output  1  write strobe, one cycle per word
- busy  output  1  load in progress
- done  output  1  last load completed
- cpu_hold  output  1  keep CPU in reset/stall
- checksum  output  16  mod-2^16 sum of words written in current/last load
- words_written  output  ADDR_W  count of words written in current/last load

Behaviour:
- Reset (async assert, sync release), all outputs and registers take these values:
  - state=IDLE
  - s_ready=0, imem_we=0, busy=0, done=0
  - cpu_hold=1
  - imem_addr=0, imem_wdata=0
  - checksum=0, words_written=0
- States are IDLE, HI, LO, WRITE, DONE.
- IDLE/DONE: start=1 does the following:
  - latches base_addr into the address pointer and length into the remaining counter
  - clears checksum, words_written and done
  - sets cpu_hold=1
  - goes to HI, or straight to DONE if length==0 (done=1, cpu_hold=0 on the next cycle)
- start is ignored in HI, LO and WRITE.
- HI: s_ready=1. A handshake (s_valid&&s_ready) latches s_data into bits [15:8] and goes to LO.
- LO: s_ready=1. A handshake latches s_data into bits [7:0] and goes to WRITE.
- WRITE: s_ready=0, imem_we=1 for exactly one cycle, with imem_addr=pointer and imem_wdata=assembled word. On that edge:
  - checksum += word, wrapping mod 2^16
  - words_written += 1
  - pointer += 1, wrapping mod 2^ADDR_W
  - remaining -= 1
  - if remaining was 1, go to DONE; otherwise go to HI
- Latency: the write strobe appears exactly 1 cycle after the low-byte handshake. Maximum throughput is 1 word per 3 cycles.
- DONE: done=1, cpu_hold=0, busy=0, s_ready=0. Held until the next start or abort.
- busy=1 in HI, LO and WRITE.
- s_valid with no handshake while not ready is simply stalled; no data is lost and the loader has no timing requirement on the source.
- abort=1 in HI, LO or WRITE:
  - next state is IDLE, with done=0 and cpu_hold stays 1
  - imem_we is suppressed in that same cycle (abort wins over WRITE)
  - checksum and words_written keep their partial values
- abort in IDLE/DONE: DONE goes to IDLE with done=0 and cpu_hold=1; IDLE is unchanged.
- start and abort together in IDLE/DONE: abort wins, start is ignored.
- The byte stream is strictly in order, high byte first. A partial word left at abort is discarded.

Test Plan:
- Reset then start with base_addr=0x0010, length=2, bytes 0x12,0x34,0xAB,0xCD -> writes at 0x0010=0x1234 and 0x0011=0xABCD, each imem_we one cycle; then done=1, cpu_hold=0, checksum=0xBE01, words_written=2.
- length=0 start -> no imem_we, s_ready never 1, done=1 and cpu_hold=0 one cycle after start.
- base_addr=0xFFFF, length=2, words 0xFFFF,0x0002 -> writes at 0xFFFF then 0x0000; checksum=0x0001.
- s_valid toggled randomly with gaps of 0-5 cycles, length=4 -> same addresses and data as a gapless run; imem_we count=4.
- abort asserted in LO of the second word -> no second write; state IDLE, done=0, cpu_hold=1, words_written=1. A following start reloads correctly from base_addr.
- start pulsed during HI, plus async rst_n low mid-WRITE -> start has no effect; on reset imem_we drops immediately and all outputs return to reset values.

Source files
------------

// File: rtl/risc16_imem_loader_if.sv
// rtl/risc16_imem_loader_if.sv - byte stream handshake between program source and loader
interface risc16_imem_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/risc16_imem_loader.sv
// rtl/risc16_imem_loader.sv - assembles big-endian program words into RiSC-16 instruction memory
module risc16_imem_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    risc16_imem_loader_if.slave s,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              imem_we,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [15:0]       checksum,
    output logic [ADDR_W-1:0] words_written
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] remaining;
    logic [15:0]       word;
    logic              ready_int;
    logic              hs;
    logic              accept_start;

    assign ready_int    = (state == ST_HI) || (state == ST_LO);
    assign hs           = s.s_valid && ready_int;
    assign accept_start = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));

    assign s.s_ready     = ready_int;
    assign imem_we       = (state == ST_WRITE) && !abort;
    assign imem_addr     = ptr;
    assign imem_wdata    = word;
    assign busy          = (state == ST_HI) || (state == ST_LO) || (state == ST_WRITE);
    assign done          = (state == ST_DONE);
    assign cpu_hold      = (state != ST_DONE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (start) begin
                    state_next = (length == '0) ? ST_DONE : ST_HI;
                end
            end
            ST_HI: begin
                if (abort)   state_next = ST_IDLE;
                else if (hs) state_next = ST_LO;
            end
            ST_LO: begin
                if (abort)   state_next = ST_IDLE;
                else if (hs) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (abort)                  state_next = ST_IDLE;
                else if (remaining == ONE)  state_next = ST_DONE;
                else                        state_next = ST_HI;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            remaining     <= '0;
            word          <= '0;
            checksum      <= '0;
            words_written <= '0;
        end else begin
            state <= state_next;
            if (accept_start) begin
                ptr           <= base_addr;
                remaining     <= length;
                checksum      <= '0;
                words_written <= '0;
            end
            // Partial words are simply overwritten by the next high byte, so abort needs no cleanup here.
            if (state == ST_HI && hs && !abort) begin
                word[15:8] <= s.s_data;
            end
            if (state == ST_LO && hs && !abort) begin
                word[7:0] <= s.s_data;
            end
            if (imem_we) begin
                checksum      <= checksum + word;
                words_written <= words_written + ONE;
                ptr           <= ptr + ONE;
                remaining     <= remaining - ONE;
            end
        end
    end

endmodule

// File: tb/tb_risc16_imem_loader.sv
// tb/tb_risc16_imem_loader.sv - scoreboard bench for risc16_imem_loader
module tb_risc16_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_we;
    logic        busy;
    logic        done;
    logic        cpu_hold;
    logic [15:0] checksum;
    logic [15:0] words_written;

    int n_cmp = 0;
    int n_err = 0;
    int we_count = 0;
    bit sready_seen = 0;
    logic [31:0] sb[$];

    risc16_imem_loader_if ifc();

    risc16_imem_loader #(.ADDR_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .base_addr     (base_addr),
        .length        (length),
        .s             (ifc.slave),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .imem_we       (imem_we),
        .busy          (busy),
        .done          (done),
        .cpu_hold      (cpu_hold),
        .checksum      (checksum),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifc.s_ready === 1'b1) sready_seen = 1'b1;
        if (imem_we === 1'b1) begin
            logic [31:0] e;
            we_count++;
            if (sb.size() == 0) begin
                chk("unexpected_write", {imem_addr, imem_wdata}, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("write_addr", {16'h0, imem_addr}, {16'h0, e[31:16]});
                chk("write_data", {16'h0, imem_wdata}, {16'h0, e[15:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [15:0] l);
        base_addr = b;
        length = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit ok = 0;
        ifc.s_valid = 1'b1;
        ifc.s_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifc.s_ready === 1'b1) begin
                step();
                ok = 1;
                break;
            end
        end
        ifc.s_valid = 1'b0;
        if (!ok) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk("done_wait", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] sum;
        int          wc;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        length = '0;
        ifc.s_valid = 1'b0;
        ifc.s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", {31'd0, ifc.s_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_addr_data", {imem_addr, imem_wdata}, 32'd0);
        chk("rst_sum_ww", {checksum, words_written}, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic two-word load
        pulse_start(16'h0010, 16'd2);
        sb.push_back({16'h0010, 16'h1234});
        sb.push_back({16'h0011, 16'hABCD});
        send_word(16'h1234);
        send_word(16'hABCD);
        wait_done();
        chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_sum", {16'd0, checksum}, 32'h0000_BE01);
        chk("t1_ww", {16'd0, words_written}, 32'd2);
        chk("t1_we_count", we_count, 32'd2);

        // Abort in DONE returns to IDLE
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("done_abort_done", {31'd0, done}, 32'd0);
        chk("done_abort_hold", {31'd0, cpu_hold}, 32'd1);

        // Zero-length load
        sready_seen = 0;
        wc = we_count;
        pulse_start(16'h0050, 16'd0);
        @(negedge clk);
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_hold", {31'd0, cpu_hold}, 32'd0);
        repeat (3) @(negedge clk);
        chk("len0_no_we", we_count, wc);
        chk("len0_no_ready", {31'd0, sready_seen}, 32'd0);
        chk("len0_ww", {16'd0, words_written}, 32'd0);

        // Address wrap at the top of memory
        step();
        pulse_start(16'hFFFF, 16'd2);
        sb.push_back({16'hFFFF, 16'hFFFF});
        sb.push_back({16'h0000, 16'h0002});
        send_word(16'hFFFF);
        send_word(16'h0002);
        wait_done();
        chk("wrap_sum", {16'd0, checksum}, 32'h0000_0001);
        chk("wrap_ww", {16'd0, words_written}, 32'd2);

        // Gappy source, four words
        step();
        wc = we_count;
        sum = '0;
        pulse_start(16'h0200, 16'd4);
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            sum = sum + w;
            sb.push_back({16'h0200 + 16'(i), w});
            repeat ($urandom_range(0, 5)) step();
            send_byte(w[15:8]);
            repeat ($urandom_range(0, 5)) step();
            send_byte(w[7:0]);
        end
        wait_done();
        chk("gap_we_count", we_count - wc, 32'd4);
        chk("gap_sum", {16'd0, checksum}, {16'd0, sum});
        chk("gap_ww", {16'd0, words_written}, 32'd4);

        // Abort in LO of the second word
        step();
        pulse_start(16'h0300, 16'd3);
        sb.push_back({16'h0300, 16'hC0DE});
        send_word(16'hC0DE);
        send_byte(8'h77);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hold", {31'd0, cpu_hold}, 32'd1);
        chk("abort_ww", {16'd0, words_written}, 32'd1);
        chk("abort_sum", {16'd0, checksum}, 32'h0000_C0DE);
        step();
        pulse_start(16'h0300, 16'd1);
        sb.push_back({16'h0300, 16'h5A5A});
        send_word(16'h5A5A);
        wait_done();
        chk("reload_ww", {16'd0, words_written}, 32'd1);
        chk("reload_sum", {16'd0, checksum}, 32'h0000_5A5A);

        // Start ignored in HI, then async reset mid-WRITE
        step();
        pulse_start(16'h0400, 16'd3);
        sb.push_back({16'h0400, 16'h1111});
        sb.push_back({16'h0401, 16'h2222});
        send_word(16'h1111);
        step();
        pulse_start(16'h0800, 16'd5);
        chk("hi_start_busy", {31'd0, busy}, 32'd1);
        chk("hi_start_ready", {31'd0, ifc.s_ready}, 32'd1);
        send_word(16'h2222);
        send_word(16'h3333);
        chk("mid_write_we", {31'd0, imem_we}, 32'd1);
        chk("mid_write_addr", {16'd0, imem_addr}, 32'h0000_0402);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", {31'd0, imem_we}, 32'd0);
        chk("arst_busy_done_hold", {29'd0, busy, done, cpu_hold}, 32'd1);
        chk("arst_ready", {31'd0, ifc.s_ready}, 32'd0);
        chk("arst_addr_data", {imem_addr, imem_wdata}, 32'd0);
        chk("arst_sum_ww", {checksum, words_written}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
